pwm_cap: RTL and testbench
==========================

Name: pwm_cap

Overview:
- Capture/decoder for the PWM/FM pulse line driven by the team's PWM generators. It runs in the same clk/run_ctrl tick domain as those generators.
- Samples an asynchronous pwm_in and measures, in run_ctrl ticks, the high time and period (PWM mode) or the half-period (FM mode).
- Publishes each measurement with a one-clock valid strobe and flags a stuck or absent line as idle.

Parameters:
- CW, 9, measurement counter/output width; max measurable interval is 2^CW-1 ticks.
- SYNC_STAGES, 2, synchroniser flops on pwm_in (minimum 2).

Ports:
- rst  input  1  asynchronous, active-low reset
- clk  input  1  clock
- run_ctrl  input  1  tick enable; all measurement state advances only on clk edges with run_ctrl=1
- cap_en  input  1  capture enable; 0 forces WAIT
- pwm_mod  input  1  0: FM, 1: PWM; latched on WAIT exit
- pwm_in  input  1  asynchronous pulse line, idle high
- high_width  output  CW  ticks the line was sampled high in last completed high phase
- period  output  CW  PWM: ticks rising-to-rising; FM: ticks edge-to-edge
- cap_valid  output  1  one-clk pulse, new period/high_width published
- idle  output  1  line saw no qualifying edge for 2^CW-1 ticks

Behaviour:
- Reset values:
  - sync flops=1, prev sample s_prev=1, state=WAIT, cnt=0, mode_r=1
  - high_width=0, period=0, cap_valid=0, idle=0
- Sampling and edge detection:
  - Synchroniser clocks every clk.
  - s_prev updates only on ticks.
  - rise = tick & s & ~s_prev; fall = tick & ~s & s_prev.
- Latency: pwm_in change reaches the outputs after SYNC_STAGES clks to the synchroniser output, then the next tick, then +1 clk (outputs are registered on the tick edge).
- cap_valid: exactly one clk high, never on a non-tick clk. All outputs hold between updates.
- Counter cnt (CW bits): an edge tick loads 1; every other tick in MEAS adds 1; cnt saturates at 2^CW-1.
- States:
  - WAIT
    - PWM (pwm_mod=1): rise moves to MEAS, cnt=1, mode_r=pwm_mod. Fall is ignored.
    - FM: any edge moves to MEAS, cnt=1, mode_r=pwm_mod.
    - Any edge in WAIT clears idle. No cap_valid from WAIT.
  - MEAS, mode_r=PWM
    - fall: high_width<=cnt; cnt<=1.
    - rise: period<=cnt+hcnt (total ticks since previous rise), cap_valid=1, cnt<=1. A separate phase counter is permitted; only the published values are normative: period = ticks between the two rising-edge ticks.
  - MEAS, mode_r=FM
    - any edge: period<=cnt, cap_valid=1, cnt<=1.
    - fall additionally: high_width<=cnt.
  - Saturation: if cnt reaches 2^CW-1 in MEAS without an edge, go to WAIT, idle<=1, no cap_valid, outputs hold.
- cap_en=0: next clk goes to WAIT (regardless of tick), cnt=0, idle=0, no cap_valid, outputs hold. An in-flight measurement is discarded.
- pwm_mod change in MEAS is ignored until the next WAIT exit.
- Async reset mid-operation: immediate return to reset values. First measurement after release needs a full qualifying cycle.
- Simultaneous cap_en=0 and edge tick: cap_en wins; no cap_valid.
- Saturation and edge on the same tick: edge wins and the measurement is published with value 2^CW-1.

Decomposition:
- Package pwm_pkg holds:
  - PWM_MOD_FM=1'b0, PWM_MOD_PWM=1'b1
  - cap state encoding (WAIT, MEAS)
  - default CW=9
- Sub-module pwm_in_sync: SYNC_STAGES synchroniser plus tick-qualified rise/fall detector with s_prev. Reset output=1. Reusable by other line receivers.

Test Plan:
- PWM, run_ctrl=1, cap_en=1, line high 52 ticks / low 204 ticks repeating -> after the 2nd rising edge cap_valid once per 256 ticks, high_width=52, period=256.
- FM, line toggling every 52 ticks -> cap_valid on every edge after the first, period=52; high_width=52 after first fall.
- PWM, run_ctrl asserted 1 clk in 4, same tick waveform as test 1 -> identical values; cap_valid only on tick clks, width 1 clk.
- PWM, line stuck high 600 ticks after a rise -> idle=1 at tick 511, no cap_valid, outputs hold. Next rise clears idle; the first cap_valid comes only after the following full period.
- Line low at reset release, PWM -> first fall ignored, no cap_valid until rise + full period. cap_en dropped mid-period -> WAIT, no strobe, outputs unchanged.
- Async rst pulse mid-MEAS with high_width=52 -> high_width=0, period=0, idle=0, cap_valid=0 immediately; cap_valid first reasserts after a full new period.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and state encoding for the PWM/FM capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  localparam logic PWM_MOD_FM  = 1'b0;
  localparam logic PWM_MOD_PWM = 1'b1;

  localparam int CW_DEFAULT = 9;

  typedef enum logic {
    CAP_WAIT = 1'b0,
    CAP_MEAS = 1'b1
  } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: synchronises an async line and flags tick-qualified rise/fall edges.
// Latency: SYNC_STAGES clks to the synchronised level, edges valid on the next tick.
// Backpressure: none; edges are single-cycle combinational strobes.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic rst,
  input  logic clk,
  input  logic tick,
  input  logic line,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain runs on every clk; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
  end

  // Previous sample advances only on ticks so edges are measured in tick time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      s_prev <= 1'b1;
    else if (tick) s_prev <= s;
  end

  assign rise = tick &  s & ~s_prev;
  assign fall = tick & ~s &  s_prev;

endmodule

// File: rtl/pwm_cap.sv
// pwm_cap: measures high time and period (PWM) or half-period (FM) of pwm_in in ticks.
// Latency: SYNC_STAGES clks + next tick + 1 clk from pwm_in change to registered outputs.
// Backpressure: none; cap_valid is a one-clk strobe, outputs hold between updates.
module pwm_cap
  import pwm_pkg::*;
#(
  parameter int CW          = CW_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          run_ctrl,
  input  logic          cap_en,
  input  logic          pwm_mod,
  input  logic          pwm_in,
  output logic [CW-1:0] high_width,
  output logic [CW-1:0] period,
  output logic          cap_valid,
  output logic          idle
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  cap_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mode_r, mode_nxt;
  logic          rise, fall, edge_t;
  logic          pub_per, pub_hw, idle_set, idle_clr;
  logic [CW-1:0] per_val;
  logic [CW:0]   pwm_sum;

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .rst  (rst),
    .clk  (clk),
    .tick (run_ctrl),
    .line (pwm_in),
    .rise (rise),
    .fall (fall)
  );

  assign edge_t = rise | fall;

  // Next state, phase counter and publish decisions; cap_en low overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_r;
    pub_per   = 1'b0;
    pub_hw    = 1'b0;
    idle_set  = 1'b0;
    idle_clr  = 1'b0;
    per_val   = cnt;
    // PWM period is low phase plus the high phase just captured into high_width;
    // edges strictly alternate, so high_width is always this cycle's high phase.
    pwm_sum   = {1'b0, cnt} + {1'b0, high_width};
    if (!cap_en) begin
      state_nxt = CAP_WAIT;
      cnt_nxt   = '0;
      idle_clr  = 1'b1;
    end else begin
      case (state)
        CAP_WAIT: begin
          idle_clr = edge_t;
          if (rise || (fall && pwm_mod == PWM_MOD_FM)) begin
            state_nxt = CAP_MEAS;
            cnt_nxt   = CW'(1);
            mode_nxt  = pwm_mod;
          end
        end
        CAP_MEAS: begin
          if (edge_t) begin
            cnt_nxt = CW'(1);
            pub_hw  = fall;
            pub_per = (mode_r == PWM_MOD_FM) || rise;
            if (mode_r == PWM_MOD_PWM)
              per_val = pwm_sum[CW] ? CNT_MAX : pwm_sum[CW-1:0];
          end else if (run_ctrl) begin
            if (cnt == CNT_MAX) begin
              state_nxt = CAP_WAIT;
              cnt_nxt   = '0;
              idle_set  = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: state_nxt = CAP_WAIT;
      endcase
    end
  end

  // State, phase counter and latched mode registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CAP_WAIT;
      cnt    <= '0;
      mode_r <= PWM_MOD_PWM;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_r <= mode_nxt;
    end
  end

  // Published measurements, strobe and idle flag; values hold unless republished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_width <= '0;
      period     <= '0;
      cap_valid  <= 1'b0;
      idle       <= 1'b0;
    end else begin
      cap_valid <= pub_per;
      if (pub_hw)  high_width <= cnt;
      if (pub_per) period     <= per_val;
      if (idle_set)      idle <= 1'b1;
      else if (idle_clr) idle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_cap.sv
// tb_pwm_cap: randomized and directed stimulus against a timestamp-based reference model.
// Latency: model delays the line by SYNC_STAGES clks before edge detection.
// Backpressure: n/a.
module tb_pwm_cap;

  localparam int CW   = 9;
  localparam int SS   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, run_ctrl, cap_en, pwm_mod, pwm_in;
  logic [CW-1:0] high_width, period;
  logic          cap_valid, idle;

  pwm_cap #(.CW(CW), .SYNC_STAGES(SS)) dut (
    .rst        (rst),
    .clk        (clk),
    .run_ctrl   (run_ctrl),
    .cap_en     (cap_en),
    .pwm_mod    (pwm_mod),
    .pwm_in     (pwm_in),
    .high_width (high_width),
    .period     (period),
    .cap_valid  (cap_valid),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: line delay queue plus tick timestamps of edges.
  bit q[$];
  bit m_sp, m_meas, m_mode;
  int m_t, m_last_edge, m_last_rise;
  int e_hw, e_per, e_vld, e_idle;
  int vcnt, ph, cyc;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SS; i++) q.push_back(1'b1);
    m_sp = 1'b1; m_meas = 1'b0; m_mode = 1'b1;
    e_hw = 0; e_per = 0; e_vld = 0; e_idle = 0;
  endtask

  task automatic model_edge(input bit rc, input bit en, input bit mod, input bit pin);
    bit s, rise, fall;
    int age;
    q.push_back(pin);
    s = q.pop_front();
    e_vld = 0;
    rise = 1'b0;
    fall = 1'b0;
    if (rc) begin
      m_t++;
      rise = s & ~m_sp;
      fall = ~s & m_sp;
      m_sp = s;
    end
    age = m_t - m_last_edge;
    if (!en) begin
      m_meas = 1'b0;
      e_idle = 0;
    end else if (!m_meas) begin
      if (rise || fall) e_idle = 0;
      if (rise || (fall && !mod)) begin
        m_meas = 1'b1; m_mode = mod; m_last_edge = m_t; m_last_rise = m_t;
      end
    end else if (rise || fall) begin
      if (fall) e_hw = age;
      if (!m_mode) begin
        e_per = age; e_vld = 1;
      end else if (rise) begin
        e_per = (m_t - m_last_rise > MAXV) ? MAXV : m_t - m_last_rise;
        e_vld = 1;
      end
      m_last_edge = m_t;
      if (rise) m_last_rise = m_t;
    end else if (rc && age >= MAXV) begin
      m_meas = 1'b0;
      e_idle = 1;
    end
  endtask

  task automatic step(input bit rc, input bit pin);
    run_ctrl = rc;
    pwm_in   = pin;
    @(posedge clk);
    cyc++;
    if (!rst) model_reset();
    else      model_edge(rc, cap_en, pwm_mod, pin);
    @(negedge clk);
    chk("hw",   int'(high_width), e_hw);
    chk("per",  int'(period),     e_per);
    chk("vld",  int'(cap_valid),  e_vld);
    chk("idle", int'(idle),       e_idle);
    if (cap_valid) vcnt++;
  endtask

  // Line is high for hi ticks then low for lo ticks; ph tracks position in ticks.
  task automatic wave(input int hi, input int lo, input int nt, input int tm);
    int done;
    bit rc;
    done = 0;
    while (done < nt) begin
      rc = (tm == 0) ? 1'b1 : (tm == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
      step(rc, ph < hi);
      if (rc) begin
        ph++;
        if (ph >= hi + lo) ph = 0;
        done++;
      end
    end
  endtask

  task automatic settle(input bit mod);
    cap_en  = 1'b0;
    pwm_mod = mod;
    repeat (6) step(1'b1, 1'b1);
    cap_en = 1'b1;
    ph     = 0;
    vcnt   = 0;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_hw",   int'(high_width), 0);
    chk("rst_per",  int'(period),     0);
    chk("rst_vld",  int'(cap_valid),  0);
    chk("rst_idle", int'(idle),       0);
    repeat (3) step(1'b1, pwm_in);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; run_ctrl = 1'b0; cap_en = 1'b0; pwm_mod = 1'b1; pwm_in = 1'b1;
    cyc = 0; ph = 0; vcnt = 0; m_t = 0; m_last_edge = 0; m_last_rise = 0;
    model_reset();
    #1;
    chk("init_hw",   int'(high_width), 0);
    chk("init_per",  int'(period),     0);
    chk("init_vld",  int'(cap_valid),  0);
    chk("init_idle", int'(idle),       0);
    repeat (3) step(1'b1, 1'b1);
    rst = 1'b1;

    // PWM 52/204, tick every clk
    settle(1'b1);
    wave(52, 204, 1280, 0);
    chk("t1_cnt", vcnt, 3);
    chk("t1_hw",  int'(high_width), 52);
    chk("t1_per", int'(period), 256);

    // FM toggling every 52 ticks
    settle(1'b0);
    wave(52, 52, 416, 0);
    chk("t2_cnt", vcnt, 6);
    chk("t2_hw",  int'(high_width), 52);
    chk("t2_per", int'(period), 52);

    // PWM with run_ctrl 1 clk in 4
    settle(1'b1);
    wave(52, 204, 1280, 1);
    chk("t3_cnt", vcnt, 3);
    chk("t3_hw",  int'(high_width), 52);
    chk("t3_per", int'(period), 256);

    // Stuck high after a rise, then recovery
    settle(1'b1);
    wave(52, 204, 768, 0);
    chk("t4_per0", int'(period), 256);
    vcnt = 0;
    ph = 0;
    wave(700, 1, 650, 0);
    chk("t4_idle", int'(idle), 1);
    chk("t4_cnt",  vcnt, 1);
    chk("t4_hw",   int'(high_width), 52);
    chk("t4_per",  int'(period), 256);
    vcnt = 0;
    ph = 0;
    wave(52, 204, 300, 0);
    chk("t4_clr",  int'(idle), 0);
    chk("t4_none", vcnt, 0);
    wave(52, 204, 300, 0);
    chk("t4_first", vcnt, 1);

    // Line low across reset release, then cap_en drop mid-period
    pwm_in = 1'b0;
    pulse_rst();
    pwm_mod = 1'b1; cap_en = 1'b1; ph = 52; vcnt = 0;
    wave(52, 204, 600, 0);
    chk("t5_cnt", vcnt, 1);
    chk("t5_hw",  int'(high_width), 52);
    chk("t5_per", int'(period), 256);
    wave(52, 204, 100, 0);
    cap_en = 1'b0;
    repeat (3) step(1'b1, pwm_in);
    chk("t5_hold_hw",  int'(high_width), 52);
    chk("t5_hold_per", int'(period), 256);
    chk("t5_nostrobe", vcnt, 1);
    cap_en = 1'b1;

    // Async reset mid-measurement
    wave(52, 204, 200, 0);
    pulse_rst();
    vcnt = 0;
    wave(52, 204, 600, 0);
    chk("t6_cnt", vcnt, 2);
    chk("t6_per", int'(period), 256);

    // Saturation coinciding with an edge publishes the maximum
    settle(1'b1);
    wave(511, 100, 1200, 0);
    chk("sat_hw",   int'(high_width), MAXV);
    chk("sat_idle", int'(idle), 0);
    wave(511, 100, 100, 0);
    chk("sat_per",  int'(period), MAXV);

    // Randomized segments
    for (int i = 0; i < 16; i++) begin
      int hi, lo, nt, tm, act;
      hi = $urandom_range(1, 300);
      if ($urandom_range(0, 3) == 0) hi = $urandom_range(400, 700);
      lo = $urandom_range(1, 300);
      nt = $urandom_range(200, 700);
      tm = $urandom_range(0, 2);
      pwm_mod = 1'($urandom_range(0, 1));
      act = $urandom_range(0, 5);
      if (ph >= hi + lo) ph = 0;
      if (act == 1) begin
        cap_en = 1'b0;
        repeat ($urandom_range(1, 3)) step(1'b1, pwm_in);
        cap_en = 1'b1;
      end else if (act == 2) begin
        pulse_rst();
      end
      wave(hi, lo, nt, tm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
